conv_result_writer: RTL and testbench

- Downstream stage of the 3x3 convolution engine. It consumes that engine's result/o_en stream in raster order: interior pixels x=1..IMG_W-2, y=1..IMG_H-2.
- It saturates each result to OUT_W bits and writes it into an internal output frame memory at y*IMG_W+x. Once the interior is complete, it zero-fills the one-pixel border.
- Exposes a synchronous read port so the top level or testbench can dump the filtered frame, plus done/busy/status flags.

---
 rtl/conv_result_writer_if.sv | 29 ++
 rtl/conv_result_writer.sv | 164 ++++++++++++++++
 tb/tb_conv_result_writer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_result_writer_if.sv
// Stream, read-port and status bundle of the convolution result writer.
// The writer is the slave; the convolution front end / frame dumper is the master.
interface conv_result_writer_if #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16,
   parameter int AW    = 18
);
   logic             start;
   logic             in_valid;
   logic [IN_W-1:0]  in_data;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [OUT_W-1:0] rd_data;
   logic             busy;
   logic             done;
   logic             err;
   logic [15:0]      sat_cnt;
   logic [AW-1:0]    pix_cnt;

   modport master (
      output start, in_valid, in_data, rd_en, rd_addr,
      input  rd_data, busy, done, err, sat_cnt, pix_cnt
   );

   modport slave (
      input  start, in_valid, in_data, rd_en, rd_addr,
      output rd_data, busy, done, err, sat_cnt, pix_cnt
   );
endinterface

// File: rtl/conv_result_writer.sv
// Convolution result writer: saturates interior results into a frame memory in
// raster order, then zero-fills the one-pixel border, and exposes a read port.
module conv_result_writer #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 16,
   parameter int IMG_W = 512,
   parameter int IMG_H = 512,
   parameter int AW    = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   conv_result_writer_if.slave   io_bus
);
   localparam int DEPTH = IMG_W * IMG_H;
   localparam int DAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NB    = 2 * IMG_W + 2 * (IMG_H - 2);

   localparam logic [IN_W-1:0] L_SAT_MAX = IN_W'((2 ** OUT_W) - 1);
   localparam logic [AW-1:0]   L_ONE     = AW'(1);
   localparam logic [AW-1:0]   L_W       = AW'(IMG_W);
   localparam logic [AW-1:0]   L_2W      = AW'(2 * IMG_W);
   localparam logic [AW-1:0]   L_WM1     = AW'(IMG_W - 1);
   localparam logic [AW-1:0]   L_WM2     = AW'(IMG_W - 2);
   localparam logic [AW-1:0]   L_HM2     = AW'(IMG_H - 2);
   localparam logic [AW-1:0]   L_BOT_OFS = AW'((IMG_H - 2) * IMG_W);
   localparam logic [AW-1:0]   L_NBM1    = AW'(NB - 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_BORDER, S_DONE} state_t;

   state_t           r_state;
   logic [AW-1:0]    r_x;
   logic [AW-1:0]    r_y;
   logic [AW-1:0]    r_bcnt;
   logic [AW-1:0]    r_pix_cnt;
   logic [15:0]      r_sat_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [OUT_W-1:0] r_rd_data;
   logic [OUT_W-1:0] r_mem [DEPTH];

   logic             w_sat;
   logic [OUT_W-1:0] w_sat_data;
   logic             w_last_int;
   logic             w_stream_we;
   logic             w_border_we;
   logic [AW-1:0]    w_stream_addr;
   logic [AW-1:0]    w_side;
   logic [AW-1:0]    w_border_addr;
   logic [AW-1:0]    w_wr_addr;
   logic [OUT_W-1:0] w_wr_data;
   logic [DAW-1:0]   w_wr_idx;
   logic [DAW-1:0]   w_rd_idx;

   assign w_sat         = io_bus.in_data > L_SAT_MAX;
   assign w_sat_data    = w_sat ? {OUT_W{1'b1}} : io_bus.in_data[OUT_W-1:0];
   assign w_last_int    = (r_x == L_WM2) && (r_y == L_HM2);
   assign w_stream_we   = (r_state == S_STREAM) && io_bus.in_valid;
   assign w_border_we   = (r_state == S_BORDER);
   assign w_stream_addr = r_y * L_W + r_x;
   assign w_wr_addr     = w_border_we ? w_border_addr : w_stream_addr;
   assign w_wr_data     = w_border_we ? '0 : w_sat_data;
   assign w_wr_idx      = DAW'(w_wr_addr);
   assign w_rd_idx      = DAW'(io_bus.rd_addr);

   // Border walk: top row, bottom row, then (0,y)/(IMG_W-1,y) pairs for y=1..IMG_H-2.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_side        = r_bcnt - L_2W;
      w_border_addr = r_bcnt;
      if (r_bcnt >= L_2W) begin
         w_border_addr = L_W + (w_side >> 1) * L_W + (w_side[0] ? L_WM1 : '0);
      end else if (r_bcnt >= L_W) begin
         w_border_addr = r_bcnt + L_BOT_OFS;
      end
   end

   // Frame control FSM with registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (rst) begin
         r_state   <= S_IDLE;
         r_x       <= '0;
         r_y       <= '0;
         r_bcnt    <= '0;
         r_pix_cnt <= '0;
         r_sat_cnt <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (io_bus.start) begin
                  r_state   <= S_STREAM;
                  r_x       <= L_ONE;
                  r_y       <= L_ONE;
                  r_sat_cnt <= '0;
                  r_pix_cnt <= '0;
                  r_err     <= io_bus.in_valid;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
               end else if (io_bus.in_valid) begin
                  r_err <= 1'b1;
               end
            end
            S_STREAM: begin
               if (io_bus.in_valid) begin
                  r_pix_cnt <= r_pix_cnt + L_ONE;
                  if (w_sat && (r_sat_cnt != 16'hFFFF)) begin
                     r_sat_cnt <= r_sat_cnt + 16'd1;
                  end
                  if (w_last_int) begin
                     r_state <= S_BORDER;
                     r_bcnt  <= '0;
                  end else if (r_x == L_WM2) begin
                     r_x <= L_ONE;
                     r_y <= r_y + L_ONE;
                  end else begin
                     r_x <= r_x + L_ONE;
                  end
               end
            end
            S_BORDER: begin
               if (io_bus.in_valid) begin
                  r_err <= 1'b1;
               end
               if (r_bcnt == L_NBM1) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_bcnt <= r_bcnt + L_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Frame memory write port: saturated results while streaming, zeros on the border.
   always_ff @(posedge clk) begin
      // NOTE: the memory has no reset so it maps onto block RAM; contents survive rst.
      if (w_stream_we || w_border_we) begin
         r_mem[w_wr_idx] <= w_wr_data;
      end
   end

   // Registered read port; same-address write in the same cycle returns old data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (io_bus.rd_en) begin
         r_rd_data <= r_mem[w_rd_idx];
      end
   end

   assign io_bus.rd_data = r_rd_data;
   assign io_bus.busy    = r_busy;
   assign io_bus.done    = r_done;
   assign io_bus.err     = r_err;
   assign io_bus.sat_cnt = r_sat_cnt;
   assign io_bus.pix_cnt = r_pix_cnt;
endmodule

// File: tb/tb_conv_result_writer.sv
// Self-checking bench for conv_result_writer on a 4x4 frame: directed protocol,
// saturation and reset cases plus randomized frames against a frame-level model.
module tb_conv_result_writer;
   localparam int IN_W    = 20;
   localparam int OUT_W   = 16;
   localparam int IMG_W   = 4;
   localparam int IMG_H   = 4;
   localparam int AW      = 18;
   localparam int NPIX    = IMG_W * IMG_H;
   localparam int NINT    = (IMG_W - 2) * (IMG_H - 2);
   localparam int NBORDER = 2 * IMG_W + 2 * (IMG_H - 2);
   localparam int SAT_MAX = (1 << OUT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   conv_result_writer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) bus ();

   conv_result_writer #(
      .IN_W(IN_W), .OUT_W(OUT_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io_bus(bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int addr;
      int exp;
   } rd_exp_t;

   rd_exp_t rd_q[$];       // expected read responses, oldest first
   int      model_mem[NPIX]; // -1 = never written
   int      slot_q[$];     // interior addresses still to be filled this frame
   int      exp_sat;
   int      exp_pix;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (frame level) ----------------
   function automatic void model_start();
      slot_q.delete();
      for (int y = 1; y <= IMG_H - 2; y++)
         for (int x = 1; x <= IMG_W - 2; x++)
            slot_q.push_back(y * IMG_W + x);
      exp_sat = 0;
      exp_pix = 0;
   endfunction

   function automatic void model_write(input int d);
      int a;
      if (slot_q.size() == 0) return;
      a = slot_q.pop_front();
      if (d > SAT_MAX) begin
         model_mem[a] = SAT_MAX;
         if (exp_sat < 65535) exp_sat++;
      end else begin
         model_mem[a] = d;
      end
      exp_pix++;
   endfunction

   function automatic void model_border();
      for (int a = 0; a < NPIX; a++) begin
         if ((a % IMG_W == 0) || (a % IMG_W == IMG_W - 1) ||
             (a / IMG_W == 0) || (a / IMG_W == IMG_H - 1))
            model_mem[a] = 0;
      end
   endfunction

   // ---------------- stimulus tasks (all return on a negedge) ----------------
   task automatic queue_read(input int a);
      if (model_mem[a] < 0) return;
      rd_q.push_back('{addr: a, exp: model_mem[a]});
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(a);
   endtask

   task automatic read_addr(input int a);
      queue_read(a);
      @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   task automatic write_pix(input int d, input int ra);
      if (ra >= 0) queue_read(ra);
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(d);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.rd_en    = 1'b0;
      model_write(d);
   endtask

   task automatic drive_start(input bit with_valid, input int d);
      bus.start    = 1'b1;
      bus.in_valid = with_valid;
      bus.in_data  = IN_W'(d);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      model_start();
   endtask

   task automatic poke_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_ignored_pix", bus.pix_cnt, exp_pix);
      check("start_ignored_busy", bus.busy, 1);
   endtask

   task automatic wait_done(input bit poke_border);
      int cnt = 0;
      while (bus.done !== 1'b1 && cnt < 64) begin
         if (poke_border && cnt == 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = IN_W'(20'h00555);
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         cnt++;
      end
      check("border_cycles", cnt, NBORDER);
      model_border();
   endtask

   task automatic check_frame_end(input int exp_err);
      check("end_done", bus.done, 1);
      check("end_busy", bus.busy, 0);
      check("end_pix_cnt", bus.pix_cnt, exp_pix);
      check("end_sat_cnt", bus.sat_cnt, exp_sat);
      check("end_err", bus.err, exp_err);
   endtask

   task automatic read_all_shuffled();
      int order[NPIX];
      int j, t;
      for (int i = 0; i < NPIX; i++) order[i] = i;
      for (int i = NPIX - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < NPIX; i++) read_addr(order[i]);
   endtask

   function automatic int rand_data();
      if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, SAT_MAX));
      return int'($urandom_range(0, 20'hFFFFF));
   endfunction

   task automatic run_random_frame();
      int ra;
      drive_start(1'b0, 0);
      check("rnd_start_sat", bus.sat_cnt, 0);
      check("rnd_start_pix", bus.pix_cnt, 0);
      check("rnd_start_busy", bus.busy, 1);
      for (int i = 0; i < NINT; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) poke_start();
         ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NPIX - 1)) : -1;
         write_pix(rand_data(), ra);
         check("rnd_pix_cnt", bus.pix_cnt, exp_pix);
      end
      wait_done(1'b0);
      check_frame_end(0);
      read_all_shuffled();
   endtask

   // ---------------- monitor: pops an expectation for every read issued ----------------
   initial begin
      bit pend;
      rd_exp_t e;
      forever begin
         @(posedge clk);
         pend = bus.rd_en;
         @(negedge clk);
         if (pend) begin
            if (rd_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL rd_unexpected: got 0x%0h with no read outstanding", bus.rd_data);
            end else begin
               e = rd_q.pop_front();
               check($sformatf("rd_data[%0d]", e.addr), bus.rd_data, e.exp);
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.rd_en    = 1'b0;
      bus.rd_addr  = '0;
      for (int i = 0; i < NPIX; i++) model_mem[i] = -1;
      exp_sat = 0;
      exp_pix = 0;

      // reset values
      #12;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_sat_cnt", bus.sat_cnt, 0);
      check("rst_pix_cnt", bus.pix_cnt, 0);
      check("rst_rd_data", bus.rd_data, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // in_valid while idle
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(123);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("idle_valid_err", bus.err, 1);
      check("idle_valid_pix", bus.pix_cnt, 0);
      check("idle_valid_busy", bus.busy, 0);

      // frame 1: 10,20,30,40 with gaps and an ignored start
      drive_start(1'b0, 0);
      check("f1_err_cleared", bus.err, 0);
      check("f1_busy", bus.busy, 1);
      check("f1_done", bus.done, 0);
      write_pix(10, -1);
      @(negedge clk);
      write_pix(20, -1);
      poke_start();
      write_pix(30, -1);
      repeat (2) @(negedge clk);
      write_pix(40, -1);
      check("f1_pix_cnt", bus.pix_cnt, 4);
      check("f1_busy_border", bus.busy, 1);
      wait_done(1'b0);
      check_frame_end(0);
      for (int a = 0; a < NPIX; a++) read_addr(a);

      // in_valid while done
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(999);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("done_valid_err", bus.err, 1);
      check("done_valid_done", bus.done, 1);
      check("done_valid_pix", bus.pix_cnt, 4);
      read_addr(5);

      // frame 2: restart from done, in_valid on the start cycle and during border
      drive_start(1'b1, 777);
      check("f2_start_err", bus.err, 1);
      check("f2_done_clear", bus.done, 0);
      check("f2_busy", bus.busy, 1);
      check("f2_pix_cnt", bus.pix_cnt, 0);
      write_pix(1, 5);  // same-address read returns the frame-1 value
      write_pix(2, -1);
      write_pix(3, -1);
      write_pix(4, -1);
      wait_done(1'b1);
      check_frame_end(1);
      read_addr(5);
      read_addr(6);
      read_addr(9);
      read_addr(10);
      read_addr(0);

      // frame 3: saturation boundaries
      drive_start(1'b0, 0);
      check("f3_err_cleared", bus.err, 0);
      write_pix(20'h10000, -1);
      check("sat_step1", bus.sat_cnt, exp_sat);
      write_pix(20'hFFFFF, -1);
      check("sat_step2", bus.sat_cnt, exp_sat);
      write_pix(16'hFFFF, -1);
      check("sat_step3", bus.sat_cnt, exp_sat);
      write_pix(7, -1);
      wait_done(1'b0);
      check_frame_end(0);
      read_all_shuffled();

      // randomized frames
      for (int f = 0; f < 4; f++) run_random_frame();

      // reset in the middle of a frame
      drive_start(1'b0, 0);
      write_pix(rand_data(), -1);
      write_pix(rand_data(), -1);
      check("mid_pix_cnt", bus.pix_cnt, 2);
      #2 rst = 1'b1;
      #1;
      check("rst_async_busy", bus.busy, 0);
      check("rst_async_done", bus.done, 0);
      check("rst_async_pix", bus.pix_cnt, 0);
      check("rst_async_err", bus.err, 0);
      check("rst_async_sat", bus.sat_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_idle_busy", bus.busy, 0);
      run_random_frame();

      repeat (3) @(negedge clk);
      check("rd_q_drained", rd_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
